// File: rtl/ar_breakpoint_unit_if.sv
// CPU bus snoop and register-window signals shared between the cartridge decoder and the breakpoint unit.
interface ar_breakpoint_unit_if #(
   parameter int unsigned ADDR_W = 23
);
   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_as_n;
   logic              cpu_rd;
   logic              reg_sel;
   logic              reg_wr;
   logic [5:0]        reg_addr;
   logic [15:0]       reg_wdata;
   logic [15:0]       reg_rdata;

   modport master (
      output cpu_address, cpu_as_n, cpu_rd, reg_sel, reg_wr, reg_addr, reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  cpu_address, cpu_as_n, cpu_rd, reg_sel, reg_wr, reg_addr, reg_wdata,
      output reg_rdata
   );
endinterface

// File: rtl/ar_breakpoint_unit.sv
// Multi-channel breakpoint / freeze controller raising a level-7 request for the Action Replay monitor.
// Optional macro AR_BP_RANGE_EN turns even/odd channel pairs into inclusive address-range comparators.
module ar_breakpoint_unit #(
   parameter int unsigned NUM_BP = 4,
   parameter int unsigned ADDR_W = 23,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   ar_breakpoint_unit_if.slave   bus,
   input  logic                  freeze,
   input  logic                  arm,
   output logic                  int7_req,
   input  logic                  int7_ack,
   output logic                  frozen
);

   localparam int unsigned HI_W = ADDR_W - 16;
`ifdef AR_BP_RANGE_EN
   localparam int unsigned CTRL_W = 5;
`else
   localparam int unsigned CTRL_W = 4;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SERVICE} state_t;

   state_t              state_q, state_d;
   logic [5:0]          status_q, status_d;
   logic                gen_q;
   logic                as_n_d, freeze_d;
   logic                ev_q, ev_rd_q;
   logic [ADDR_W-1:0]   ev_addr_q;
   logic [CTRL_W-1:0]   ctrl_q [NUM_BP];
   logic [ADDR_W-1:0]   addr_q [NUM_BP];
   logic [CNT_W-1:0]    cnt_q  [NUM_BP];
   logic [NUM_BP-1:0]   match, trig;
   logic [3:0]          hit_ch;
   logic                idle, reg_we, freeze_rise, resume;
   logic [15:0]         rdata;

   assign idle        = (state_q == ST_IDLE);
   assign reg_we      = bus.reg_sel & bus.reg_wr;
   assign freeze_rise = freeze & ~freeze_d & arm;
   assign resume      = reg_we & (bus.reg_addr == 6'h00) & bus.reg_wdata[15];

   // Bus-cycle start detection: address and direction captured on the strobe's falling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         as_n_d    <= 1'b1;
         freeze_d  <= 1'b0;
         ev_q      <= 1'b0;
         ev_rd_q   <= 1'b0;
         ev_addr_q <= '0;
      end else begin
         as_n_d   <= bus.cpu_as_n;
         freeze_d <= freeze;
         ev_q     <= as_n_d & ~bus.cpu_as_n;
         if (as_n_d & ~bus.cpu_as_n) begin
            ev_addr_q <= bus.cpu_address;
            ev_rd_q   <= bus.cpu_rd;
         end
      end
   end

   for (genvar n = 0; n < NUM_BP; n++) begin : g_ch
      logic filt, base;
      assign filt = (ev_rd_q & ctrl_q[n][1]) | (~ev_rd_q & ctrl_q[n][2]);
      assign base = ev_q & ctrl_q[n][0] & gen_q & arm & filt;
`ifdef AR_BP_RANGE_EN
      if ((n % 2 == 0) && (n + 1 < NUM_BP)) begin : g_lo
         assign match[n] = base & (ctrl_q[n][4] ?
                           ((ev_addr_q >= addr_q[n]) && (ev_addr_q <= addr_q[n+1])) :
                           (ev_addr_q == addr_q[n]));
      end else if (n % 2 == 1) begin : g_hi
         // Upper bound of a range pair stops acting as its own comparator.
         assign match[n] = base & ~ctrl_q[n-1][4] & (ev_addr_q == addr_q[n]);
      end else begin : g_solo
         assign match[n] = base & (ev_addr_q == addr_q[n]);
      end
`else
      assign match[n] = base & (ev_addr_q == addr_q[n]);
`endif
      assign trig[n] = idle & match[n] & (cnt_q[n] == '0);
   end

   // Lowest-index triggering channel is the one reported.
   always_comb begin
      hit_ch = 4'd0;
      for (int n = int'(NUM_BP) - 1; n >= 0; n--) begin
         if (trig[n]) hit_ch = 4'(n);
      end
   end

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      case (state_q)
         ST_IDLE: begin
            if (freeze_rise) begin
               state_d  = ST_PEND;
               status_d = 6'h10;
            end else if (|trig) begin
               state_d  = ST_PEND;
               status_d = {2'b10, hit_ch};
            end
         end
         ST_PEND:    if (int7_ack) state_d = ST_SERVICE;
         ST_SERVICE: if (resume)   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         status_q <= '0;
         int7_req <= 1'b0;
         frozen   <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         int7_req <= (state_d == ST_PEND);
         frozen   <= (state_d != ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) gen_q <= 1'b0;
      else if (reg_we && bus.reg_addr == 6'h00) gen_q <= bus.reg_wdata[0];
   end

   // Channel registers: a register write in the same clk overrides the hardware update.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < int'(NUM_BP); n++) begin
            ctrl_q[n] <= '0;
            addr_q[n] <= '0;
            cnt_q[n]  <= '0;
         end
      end else begin
         for (int n = 0; n < int'(NUM_BP); n++) begin
            if (idle && match[n] && cnt_q[n] != '0) cnt_q[n] <= cnt_q[n] - CNT_W'(1);
            if (trig[n] && ctrl_q[n][3]) ctrl_q[n][0] <= 1'b0;
            if (reg_we && bus.reg_addr == 6'(8 + 4*n)) begin
`ifdef AR_BP_RANGE_EN
               ctrl_q[n] <= {((n % 2 == 0) && (n + 1 < int'(NUM_BP))) ? bus.reg_wdata[4] : 1'b0,
                             bus.reg_wdata[3:0]};
`else
               ctrl_q[n] <= bus.reg_wdata[3:0];
`endif
            end
            if (reg_we && bus.reg_addr == 6'(9 + 4*n))  addr_q[n][15:0]       <= bus.reg_wdata;
            if (reg_we && bus.reg_addr == 6'(10 + 4*n)) addr_q[n][ADDR_W-1:16] <= bus.reg_wdata[HI_W-1:0];
            if (reg_we && bus.reg_addr == 6'(11 + 4*n)) cnt_q[n]               <= bus.reg_wdata[CNT_W-1:0];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.reg_sel) begin
         if (bus.reg_addr == 6'h00) rdata = {15'd0, gen_q};
         if (bus.reg_addr == 6'h01) rdata = {10'd0, status_q};
         for (int n = 0; n < int'(NUM_BP); n++) begin
            if (bus.reg_addr[5:2] == 4'(n + 2)) begin
               case (bus.reg_addr[1:0])
                  2'd0:    rdata = 16'(ctrl_q[n]);
                  2'd1:    rdata = addr_q[n][15:0];
                  2'd2:    rdata = 16'(addr_q[n][ADDR_W-1:16]);
                  default: rdata = 16'(cnt_q[n]);
               endcase
            end
         end
      end
   end

   assign bus.reg_rdata = rdata;

endmodule

// File: tb/tb_ar_breakpoint_unit.sv
// Directed self-checking bench for ar_breakpoint_unit (default 4 channels, 23-bit address, 8-bit counters).
module tb_ar_breakpoint_unit;

   logic clk = 1'b0;
   logic reset, freeze, arm, int7_ack;
   logic int7_req, frozen;
   int   n_cmp = 0;
   int   n_bad = 0;

   ar_breakpoint_unit_if #(.ADDR_W(23)) bus ();

   ar_breakpoint_unit #(.NUM_BP(4), .ADDR_W(23), .CNT_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .freeze   (freeze),
      .arm      (arm),
      .int7_req (int7_req),
      .int7_ack (int7_ack),
      .frozen   (frozen)
   );

   always #5 clk = ~clk;

   task automatic reg_write(input logic [5:0] a, input logic [15:0] d);
      bus.reg_sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
      @(negedge clk);
      bus.reg_sel = 1'b0; bus.reg_wr = 1'b0;
   endtask

   task automatic reg_read(input logic [5:0] a, output logic [15:0] d);
      bus.reg_sel = 1'b1; bus.reg_addr = a;
      #1 d = bus.reg_rdata;
      bus.reg_sel = 1'b0;
   endtask

   // One bus cycle; reports int7_req during the event cycle and one clk later.
   task automatic cpu_access(input logic [22:0] a, input logic rd, input logic frz,
                             output logic r_ev, output logic r_after);
      bus.cpu_address = a; bus.cpu_rd = rd; bus.cpu_as_n = 1'b0;
      @(negedge clk);
      if (frz) freeze = 1'b1;
      r_ev = int7_req;
      @(negedge clk);
      r_after = int7_req;
      bus.cpu_as_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic ack_resume();
      int7_ack = 1'b1; @(negedge clk); int7_ack = 1'b0;
      reg_write(6'h00, 16'h8001);
   endtask

   task automatic test_reset();
      logic [15:0] d;
      reset = 1'b1; @(negedge clk); @(negedge clk);
      n_cmp++; if (int7_req !== 1'b0 || frozen !== 1'b0) begin n_bad++;
         $display("FAIL reset_outputs: int7_req=%b frozen=%b required 0 0", int7_req, frozen); end
      reset = 1'b0; @(negedge clk);
      reg_read(6'h01, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_status: got %h required 0000", d); end
      reg_read(6'h00, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_gctrl: got %h required 0000", d); end
   endtask

   task automatic test_regmap();
      logic [15:0] d;
      reg_read(6'h02, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL unmapped_02: got %h required 0000", d); end
      reg_write(6'h18, 16'hFFFF);
      reg_read(6'h18, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL unmapped_18: got %h required 0000", d); end
      reg_write(6'h09, 16'hBEEF);
      bus.reg_sel = 1'b0; bus.reg_addr = 6'h09; #1 d = bus.reg_rdata;
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL rdata_gated: got %h required 0000", d); end
      reg_read(6'h09, d);
      n_cmp++; if (d !== 16'hBEEF) begin n_bad++; $display("FAIL addr_lo_rw: got %h required BEEF", d); end
      reg_write(6'h08, 16'h001F);
      reg_read(6'h08, d);
`ifdef AR_BP_RANGE_EN
      n_cmp++; if (d !== 16'h001F) begin n_bad++; $display("FAIL ctrl_range_bit: got %h required 001F", d); end
`else
      n_cmp++; if (d !== 16'h000F) begin n_bad++; $display("FAIL ctrl_range_bit: got %h required 000F", d); end
`endif
      reg_write(6'h08, 16'h0000);
   endtask

   task automatic test_basic_read();
      logic r_ev, r_after;
      logic [15:0] d;
      reg_write(6'h08, 16'h0003);
      reg_write(6'h09, 16'hF000);
      reg_write(6'h0A, 16'h005F);
      reg_write(6'h0B, 16'h0000);
      reg_write(6'h00, 16'h0001);
      cpu_access(23'h5FF000, 1'b1, 1'b0, r_ev, r_after);
      n_cmp++; if (r_ev !== 1'b0 || r_after !== 1'b1) begin n_bad++;
         $display("FAIL bp_latency: ev=%b after=%b required 0 1", r_ev, r_after); end
      reg_read(6'h01, d);
      n_cmp++; if (d !== 16'h0020) begin n_bad++; $display("FAIL bp_status: got %h required 0020", d); end
      int7_ack = 1'b1; @(negedge clk); int7_ack = 1'b0;
      n_cmp++; if (int7_req !== 1'b0 || frozen !== 1'b1) begin n_bad++;
         $display("FAIL service: int7_req=%b frozen=%b required 0 1", int7_req, frozen); end
      reg_write(6'h00, 16'h8001);
      n_cmp++; if (frozen !== 1'b0) begin n_bad++; $display("FAIL resume: frozen=%b required 0", frozen); end
      reg_read(6'h00, d);
      n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL gctrl_selfclear: got %h required 0001", d); end
   endtask

   task automatic test_pass_count();
      logic r_ev, r_after;
      logic [15:0] d;
      reg_write(6'h0C, 16'h0005);
      reg_write(6'h0D, 16'h1234);
      reg_write(6'h0E, 16'h0001);
      reg_write(6'h0F, 16'h0002);
      cpu_access(23'h011234, 1'b0, 1'b0, r_ev, r_after);
      reg_read(6'h0F, d);
      n_cmp++; if (r_after !== 1'b0 || d !== 16'h0001) begin n_bad++;
         $display("FAIL pass1: req=%b count=%h required 0 0001", r_after, d); end
      cpu_access(23'h011234, 1'b0, 1'b0, r_ev, r_after);
      n_cmp++; if (r_after !== 1'b0) begin n_bad++; $display("FAIL pass2: req=%b required 0", r_after); end
      cpu_access(23'h011234, 1'b0, 1'b0, r_ev, r_after);
      reg_read(6'h01, d);
      n_cmp++; if (r_after !== 1'b1 || d !== 16'h0021) begin n_bad++;
         $display("FAIL pass3_trigger: req=%b status=%h required 1 0021", r_after, d); end
      ack_resume();
      reg_read(6'h0F, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL count_nowrap: got %h required 0000", d); end
      cpu_access(23'h011234, 1'b1, 1'b0, r_ev, r_after);
      n_cmp++; if (r_after !== 1'b0) begin n_bad++; $display("FAIL write_filter: req=%b required 0", r_after); end
   endtask

   task automatic test_freeze_priority();
      logic r_ev, r_after;
      logic [15:0] d;
      reg_write(6'h10, 16'h0003);
      reg_write(6'h11, 16'h0100);
      reg_write(6'h12, 16'h0000);
      reg_write(6'h13, 16'h0000);
      cpu_access(23'h000100, 1'b1, 1'b1, r_ev, r_after);
      reg_read(6'h01, d);
      n_cmp++; if (r_after !== 1'b1 || d !== 16'h0010) begin n_bad++;
         $display("FAIL freeze_wins: req=%b status=%h required 1 0010", r_after, d); end
      reg_write(6'h00, 16'h8001);
      n_cmp++; if (frozen !== 1'b1 || int7_req !== 1'b1) begin n_bad++;
         $display("FAIL resume_in_pend: frozen=%b req=%b required 1 1", frozen, int7_req); end
      int7_ack = 1'b1; @(negedge clk); int7_ack = 1'b0;
      freeze = 1'b0; @(negedge clk);
      freeze = 1'b1; @(negedge clk); @(negedge clk);
      reg_read(6'h01, d);
      n_cmp++; if (int7_req !== 1'b0 || frozen !== 1'b1 || d !== 16'h0010) begin n_bad++;
         $display("FAIL freeze_in_service: req=%b frozen=%b status=%h required 0 1 0010", int7_req, frozen, d); end
      freeze = 1'b0;
      reg_write(6'h00, 16'h8001);
      reg_write(6'h10, 16'h0000);
   endtask

   task automatic test_oneshot_priority();
      logic r_ev, r_after;
      logic [15:0] d;
      reg_write(6'h08, 16'h0003);
      reg_write(6'h09, 16'hAAAA);
      reg_write(6'h0A, 16'h0002);
      reg_write(6'h14, 16'h000B);
      reg_write(6'h15, 16'hAAAA);
      reg_write(6'h16, 16'h0002);
      reg_write(6'h17, 16'h0000);
      cpu_access(23'h02AAAA, 1'b1, 1'b0, r_ev, r_after);
      reg_read(6'h01, d);
      n_cmp++; if (r_after !== 1'b1 || d !== 16'h0020) begin n_bad++;
         $display("FAIL lowest_channel: req=%b status=%h required 1 0020", r_after, d); end
      reg_read(6'h14, d);
      n_cmp++; if (d !== 16'h000A) begin n_bad++; $display("FAIL oneshot_clear: got %h required 000A", d); end
      ack_resume();
      cpu_access(23'h02AAAA, 1'b1, 1'b0, r_ev, r_after);
      reg_read(6'h01, d);
      n_cmp++; if (r_after !== 1'b1 || d !== 16'h0020) begin n_bad++;
         $display("FAIL retrigger_ch0: req=%b status=%h required 1 0020", r_after, d); end
      ack_resume();
      reg_write(6'h08, 16'h0000);
      cpu_access(23'h02AAAA, 1'b1, 1'b0, r_ev, r_after);
      n_cmp++; if (r_after !== 1'b0) begin n_bad++; $display("FAIL ch3_disarmed: req=%b required 0", r_after); end
   endtask

   task automatic test_reset_and_arm();
      logic r_ev, r_after;
      logic [15:0] d;
      reg_write(6'h08, 16'h0003);
      cpu_access(23'h02AAAA, 1'b1, 1'b0, r_ev, r_after);
      n_cmp++; if (r_after !== 1'b1) begin n_bad++; $display("FAIL pend_before_reset: req=%b required 1", r_after); end
      reset = 1'b1; @(negedge clk);
      n_cmp++; if (int7_req !== 1'b0 || frozen !== 1'b0) begin n_bad++;
         $display("FAIL reset_in_pend: req=%b frozen=%b required 0 0", int7_req, frozen); end
      reg_read(6'h08, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_ch0_ctrl: got %h required 0000", d); end
      reg_read(6'h09, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_ch0_addr: got %h required 0000", d); end
      reg_read(6'h01, d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_status_pend: got %h required 0000", d); end
      reset = 1'b0; @(negedge clk);
      reg_write(6'h08, 16'h0003);
      reg_write(6'h09, 16'hF000);
      reg_write(6'h0A, 16'h005F);
      reg_write(6'h00, 16'h0001);
      arm = 1'b0;
      cpu_access(23'h5FF000, 1'b1, 1'b1, r_ev, r_after);
      n_cmp++; if (r_after !== 1'b0 || frozen !== 1'b0) begin n_bad++;
         $display("FAIL disarmed: req=%b frozen=%b required 0 0", r_after, frozen); end
      freeze = 1'b0; arm = 1'b1; @(negedge clk);
      cpu_access(23'h5FF000, 1'b1, 1'b0, r_ev, r_after);
      n_cmp++; if (r_after !== 1'b1) begin n_bad++; $display("FAIL rearmed: req=%b required 1", r_after); end
      ack_resume();
   endtask

`ifdef AR_BP_RANGE_EN
   task automatic test_range();
      logic r_ev, r_after;
      logic [15:0] d;
      reg_write(6'h08, 16'h0013);
      reg_write(6'h09, 16'h0100);
      reg_write(6'h0A, 16'h0000);
      reg_write(6'h0D, 16'h01FF);
      reg_write(6'h0E, 16'h0000);
      cpu_access(23'h0001FF, 1'b1, 1'b0, r_ev, r_after);
      reg_read(6'h01, d);
      n_cmp++; if (r_after !== 1'b1 || d !== 16'h0020) begin n_bad++;
         $display("FAIL range_top: req=%b status=%h required 1 0020", r_after, d); end
      ack_resume();
      cpu_access(23'h000200, 1'b1, 1'b0, r_ev, r_after);
      n_cmp++; if (r_after !== 1'b0) begin n_bad++; $display("FAIL range_above: req=%b required 0", r_after); end
   endtask
`endif

   initial begin
      reset = 1'b1; freeze = 1'b0; arm = 1'b1; int7_ack = 1'b0;
      bus.cpu_address = '0; bus.cpu_as_n = 1'b1; bus.cpu_rd = 1'b0;
      bus.reg_sel = 1'b0; bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
      @(negedge clk);
      test_reset();
      test_regmap();
      test_basic_read();
      test_pass_count();
      test_freeze_priority();
      test_oneshot_priority();
      test_reset_and_arm();
`ifdef AR_BP_RANGE_EN
      test_range();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
